start_sched: RTL and testbench

//   Arbitrates start requests from RN instruction-parse nodes onto a single

---
 rtl/start_sched.sv | 125 ++++++++++++
 tb/tb_start_sched.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/start_sched.sv
// Start scheduler: grants one prioritised, round-robin-fair request at a time
// to a shared compute engine and watches the running job for a hang.
module start_sched #(
  parameter int unsigned RN  = 4,
  parameter int unsigned IDW = 2,
  parameter int unsigned PW  = 2,
  parameter int unsigned TOW = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RN-1:0]    req_valid,
  input  logic [RN*PW-1:0] req_prior,
  output logic [RN-1:0]    req_ready,
  output logic             eng_start,
  output logic [IDW-1:0]   eng_id,
  output logic [PW-1:0]    eng_prior,
  input  logic             eng_ready,
  input  logic             eng_done,
  output logic             busy,
  output logic             timeout_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  // Last watchdog value before expiry: the RUN cycle holding this value is the
  // (2**TOW-1)-th one.
  localparam logic [TOW-1:0] WD_LAST = TOW'((2 ** TOW) - 2);

  logic [1:0]     state, next_state;
  logic [IDW-1:0] ptr, ptr_next, win;
  logic [PW-1:0]  max_p, win_p, cand_p;
  logic [TOW-1:0] wd;
  logic           any_req, found, wd_expire, accept;
  int unsigned    scan;

  assign any_req   = |req_valid;
  assign wd_expire = (wd == WD_LAST);
  assign accept    = (state == S_IDLE) && any_req;

  // Highest valid priority, then first holder of it at or after the pointer.
  always_comb begin
    max_p  = '0;
    win    = '0;
    win_p  = '0;
    cand_p = '0;
    found  = 1'b0;
    scan   = 0;
    for (int unsigned i = 0; i < RN; i++) begin
      if (req_valid[i] && (req_prior[PW*i +: PW] > max_p)) begin
        max_p = req_prior[PW*i +: PW];
      end
    end
    for (int unsigned k = 0; k < RN; k++) begin
      scan = 32'(ptr) + k;
      if (scan >= RN) begin
        scan = scan - RN;
      end
      cand_p = req_prior[PW*scan +: PW];
      if (!found && req_valid[scan] && (cand_p == max_p)) begin
        found = 1'b1;
        win   = IDW'(scan);
        win_p = cand_p;
      end
    end
  end

  assign ptr_next = (win == IDW'(RN - 1)) ? '0 : win + IDW'(1);

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[win] = 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (any_req) next_state = S_ISSUE;
      S_ISSUE: if (eng_ready) next_state = S_RUN;
      S_RUN:   if (eng_done || wd_expire) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_start   <= 1'b0;
      busy        <= 1'b0;
      eng_id      <= '0;
      eng_prior   <= '0;
      ptr         <= '0;
      wd          <= '0;
      timeout_err <= 1'b0;
    end else begin
      eng_start <= (next_state == S_ISSUE);
      busy      <= (next_state != S_IDLE);
      if (accept) begin
        eng_id    <= win;
        eng_prior <= win_p;
        ptr       <= ptr_next;
      end
      if (state == S_ISSUE) begin
        wd <= '0;
      end else if (state == S_RUN) begin
        wd <= wd + TOW'(1);
      end
      // A completion in the expiry cycle takes precedence over the error.
      if ((state == S_RUN) && !eng_done && wd_expire) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_start_sched.sv
// Bench for start_sched: a cycle-level job model checked every cycle, plus
// directed scenarios with hand-computed grants and timing.
module tb_start_sched;
  localparam int RN  = 4;
  localparam int IDW = 2;
  localparam int PW  = 2;
  localparam int TOW = 4;

  localparam int P_IDLE  = 0;
  localparam int P_ISSUE = 1;
  localparam int P_RUN   = 2;

  logic             clk;
  logic             rst_n;
  logic [RN-1:0]    req_valid;
  logic [RN*PW-1:0] req_prior;
  logic [RN-1:0]    req_ready;
  logic             eng_start;
  logic [IDW-1:0]   eng_id;
  logic [PW-1:0]    eng_prior;
  logic             eng_ready;
  logic             eng_done;
  logic             busy;
  logic             timeout_err;

  int n_checks = 0;
  int n_pass   = 0;

  // Model of the job lifecycle
  int m_phase = P_IDLE;
  int m_ptr   = 0;
  int m_id    = 0;
  int m_prior = 0;
  int m_run   = 0;
  bit m_start = 1'b0;
  bit m_busy  = 1'b0;
  bit m_to    = 1'b0;

  start_sched #(.RN(RN), .IDW(IDW), .PW(PW), .TOW(TOW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_prior(req_prior), .req_ready(req_ready),
    .eng_start(eng_start), .eng_id(eng_id), .eng_prior(eng_prior),
    .eng_ready(eng_ready), .eng_done(eng_done),
    .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Highest priority wins; ties go to the smallest forward distance from ptr.
  function automatic int pick(input logic [RN-1:0] v, input logic [RN*PW-1:0] p, input int ptr);
    int best, bestp, bestd, pr, d;
    best = -1; bestp = -1; bestd = RN;
    for (int i = 0; i < RN; i++) begin
      if (v[i]) begin
        pr = int'(p[PW*i +: PW]);
        d  = (i - ptr + RN) % RN;
        if (pr > bestp || (pr == bestp && d < bestd)) begin
          best = i; bestp = pr; bestd = d;
        end
      end
    end
    return best;
  endfunction

  always @(negedge clk) begin
    logic [RN-1:0] exp_rdy;
    int w;
    if (!rst_n) begin
      m_phase = P_IDLE; m_ptr = 0; m_id = 0; m_prior = 0; m_run = 0;
      m_start = 1'b0; m_busy = 1'b0; m_to = 1'b0;
    end
    exp_rdy = '0;
    w = pick(req_valid, req_prior, m_ptr);
    if (rst_n && m_phase == P_IDLE && w >= 0) exp_rdy[w] = 1'b1;
    chk("m_req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("m_eng_start", 32'(eng_start), 32'(m_start));
    chk("m_eng_id", 32'(eng_id), 32'(m_id));
    chk("m_eng_prior", 32'(eng_prior), 32'(m_prior));
    chk("m_busy", 32'(busy), 32'(m_busy));
    chk("m_timeout_err", 32'(timeout_err), 32'(m_to));
    if (rst_n) begin
      case (m_phase)
        P_IDLE: if (w >= 0) begin
          m_id = w; m_prior = int'(req_prior[PW*w +: PW]); m_ptr = (w + 1) % RN;
          m_phase = P_ISSUE; m_start = 1'b1; m_busy = 1'b1;
        end
        P_ISSUE: if (eng_ready) begin
          m_phase = P_RUN; m_start = 1'b0; m_run = 0;
        end
        default: begin
          m_run++;
          if (eng_done) begin
            m_phase = P_IDLE; m_busy = 1'b0;
          end else if (m_run == (1 << TOW) - 1) begin
            m_to = 1'b1; m_phase = P_IDLE; m_busy = 1'b0;
          end
        end
      endcase
    end
  end

  // Wait for an accept, launch after rdy_delay ISSUE cycles, complete after
  // run_len RUN cycles (run_len < 0: return in the first RUN cycle).
  task automatic do_job(input int rdy_delay, input int run_len, input bit drop,
                        input logic [RN-1:0] late, input int exp_id);
    int n, gid;
    n = 0; gid = -1;
    @(negedge clk);
    while (req_ready == '0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (req_ready == '0) begin
      chk("accept_wait", 32'(req_ready), 32'(1) << exp_id);
      return;
    end
    for (int i = 0; i < RN; i++) if (req_ready[i]) gid = i;
    chk("grant_id", 32'(gid), 32'(exp_id));
    @(posedge clk); #1;
    if (drop) req_valid[gid] = 1'b0;
    req_valid = req_valid | late;
    eng_ready = 1'b0;
    repeat (rdy_delay) begin
      chk("hold_start", 32'(eng_start), 32'd1);
      chk("hold_id", 32'(eng_id), 32'(exp_id));
      @(posedge clk); #1;
    end
    eng_ready = 1'b1;
    @(posedge clk); #1;
    eng_ready = 1'b0;
    if (run_len < 0) return;
    repeat (run_len - 1) begin
      @(posedge clk); #1;
    end
    eng_done = 1'b1;
    @(posedge clk); #1;
    eng_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; req_prior = '0; eng_ready = 1'b0; eng_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_start", 32'(eng_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_id", 32'(eng_id), 32'd0);
    chk("rst_to", 32'(timeout_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single request from node 2 at priority 1
    @(posedge clk); #1;
    req_valid = 4'b0100; req_prior = 8'b00_01_00_00;
    @(negedge clk);
    chk("t1_ready", 32'(req_ready), 32'h4);
    @(posedge clk); #1;
    req_valid = '0; eng_ready = 1'b1;
    @(negedge clk);
    chk("t1_start", 32'(eng_start), 32'd1);
    chk("t1_id", 32'(eng_id), 32'd2);
    chk("t1_prior", 32'(eng_prior), 32'd1);
    @(posedge clk); #1;
    eng_ready = 1'b0; eng_done = 1'b1;
    @(posedge clk); #1;
    eng_done = 1'b0;

    // Priorities {3,1,3,0}: nodes 0 and 2 alternate, node 1 starves
    req_valid = 4'b1111; req_prior = 8'b00_11_01_11;
    do_job(0, 2, 1'b0, '0, 0);
    do_job(1, 3, 1'b0, '0, 2);
    do_job(0, 1, 1'b0, '0, 0);
    req_valid = '0;

    // Reset to zero the pointer, then equal priorities rotate 0..3 twice
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    req_valid = 4'b1111; req_prior = 8'b10_10_10_10;
    for (int j = 0; j < 8; j++) do_job(j % 2, 1 + (j % 3), 1'b0, '0, j % 4);
    req_valid = '0;

    // Engine stalls 5 cycles; node 3 arrives during ISSUE and must wait
    req_valid = 4'b0010; req_prior = 8'b01_00_10_00;
    do_job(5, 2, 1'b1, 4'b1000, 1);
    do_job(0, 2, 1'b1, '0, 3);
    req_valid = '0;

    // Hung job: watchdog expires after 15 RUN cycles
    req_valid = 4'b0001; req_prior = 8'b00_00_00_11;
    do_job(0, -1, 1'b1, '0, 0);
    repeat (14) begin
      @(posedge clk); #1;
    end
    chk("t5_to_before", 32'(timeout_err), 32'd0);
    chk("t5_busy_before", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("t5_to_after", 32'(timeout_err), 32'd1);
    chk("t5_busy_after", 32'(busy), 32'd0);
    req_valid = 4'b0100; req_prior = 8'b00_01_00_00;
    do_job(0, 2, 1'b1, '0, 2);
    chk("t5_to_sticky", 32'(timeout_err), 32'd1);

    // eng_done in ISSUE is ignored; reset during RUN clears everything
    req_valid = 4'b0010; req_prior = 8'b00_00_10_00;
    @(negedge clk);
    chk("t6_ready", 32'(req_ready), 32'h2);
    @(posedge clk); #1;
    req_valid = '0; eng_done = 1'b1;
    @(posedge clk); #1;
    eng_done = 1'b0;
    chk("t6_issue_start", 32'(eng_start), 32'd1);
    chk("t6_issue_busy", 32'(busy), 32'd1);
    eng_ready = 1'b1;
    @(posedge clk); #1;
    eng_ready = 1'b0;
    chk("t6_run_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_id", 32'(eng_id), 32'd0);
    chk("t6_rst_prior", 32'(eng_prior), 32'd0);
    chk("t6_rst_to", 32'(timeout_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_valid = 4'b1111; req_prior = 8'b01_01_01_01;
    do_job(0, 1, 1'b1, '0, 0);
    req_valid = '0;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
